// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one clocked write port,
// optional write-through bypass, optional hardwired-zero r0 and a sequenced bulk clear.

module reg_file_param_rdport #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               fwd_en,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  output logic [DATA_W-1:0]                  data
);
  // The zero-register override sits last so it beats the bypass path.
  always_comb begin
    data = mem[addr];
    if (BYPASS && fwd_en && (addr == waddr)) data = wdata;
    if (ZERO_REG0 && (addr == '0))           data = '0;
  end
endmodule

module reg_file_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddrA,
  output logic [DATA_W-1:0] readDataA,
  input  logic [ADDR_W-1:0] readAddrB,
  output logic [DATA_W-1:0] readDataB,
  input  logic              clr,
  output logic              busy,
  output logic              wr_drop
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  state_t                        state, state_n;
  logic [ADDR_W-1:0]             idx, idx_n;
  logic                          zero_hit;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  assign busy     = (state == CLEAR);
  assign zero_hit = ZERO_REG0 && (writeAddr == '0);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: if (clr) begin
        state_n = CLEAR;
        idx_n   = '0;
      end
      CLEAR: begin
        idx_n = idx + ADDR_W'(1);
        if (idx == ADDR_W'(DEPTH - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The sweep owns the array while busy; host writes are dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem     <= '0;
      state   <= IDLE;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      wr_drop <= write && busy && !zero_hit;
      if (busy)                       mem[idx]       <= '0;
      else if (write && !zero_hit)    mem[writeAddr] <= writeData;
    end
  end

  assign raddr     = {readAddrB, readAddrA};
  assign readDataA = rdata[0];
  assign readDataB = rdata[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_param_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG0(ZERO_REG0)
    ) u_rd (
      .mem   (mem),
      .addr  (raddr[p]),
      .fwd_en(write && !busy),
      .waddr (writeAddr),
      .wdata (writeData),
      .data  (rdata[p])
    );
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: stimulus queues expectations, a negedge monitor checks them.

module tb_reg_file_param;
  logic       clk = 1'b0;
  logic       reset, write, clr;
  logic [2:0] writeAddr, readAddrA, readAddrB;
  logic [7:0] writeData;
  logic [7:0] rdA, rdB, nbA, nbB, zA, zB;
  logic       busy, drop, nb_busy, nb_drop, z_busy, z_drop;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG0(1'b0)) dut (
    .clk(clk), .reset(reset), .write(write), .writeAddr(writeAddr), .writeData(writeData),
    .readAddrA(readAddrA), .readDataA(rdA), .readAddrB(readAddrB), .readDataB(rdB),
    .clr(clr), .busy(busy), .wr_drop(drop));

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG0(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .write(write), .writeAddr(writeAddr), .writeData(writeData),
    .readAddrA(readAddrA), .readDataA(nbA), .readAddrB(readAddrB), .readDataB(nbB),
    .clr(clr), .busy(nb_busy), .wr_drop(nb_drop));

  reg_file_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG0(1'b1)) dut_z (
    .clk(clk), .reset(reset), .write(write), .writeAddr(writeAddr), .writeData(writeData),
    .readAddrA(readAddrA), .readDataA(zA), .readAddrB(readAddrB), .readDataB(zB),
    .clr(clr), .busy(z_busy), .wr_drop(z_drop));

  // kind: 0 rdA, 1 rdB, 2 busy, 3 wr_drop, 4 no-bypass rdA, 5 zero-reg rdA, 6 zero-reg wr_drop
  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input string n, input int k, input logic [7:0] e);
    exp_t x;
    x.name = n; x.kind = k; x.exp = e;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    write = 1'b1; writeAddr = a; writeData = d;
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = rdA;
        1:       act = rdB;
        2:       act = {7'd0, busy};
        3:       act = {7'd0, drop};
        4:       act = nbA;
        5:       act = zA;
        default: act = {7'd0, z_drop};
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; write = 1'b0; clr = 1'b0;
    writeAddr = '0; writeData = '0; readAddrA = '0; readAddrB = '0;
    #1 reset = 1'b0;

    // reset: every address reads zero on both ports
    for (int a = 0; a < 8; a += 2) begin
      readAddrA = 3'(a); readAddrB = 3'(a + 1);
      push("rst_rdA", 0, 8'h00); push("rst_rdB", 1, 8'h00);
      if (a == 0) begin
        push("rst_busy", 2, 8'h0); push("rst_drop", 3, 8'h0); push("rst_zA", 5, 8'h00);
      end
      @(negedge clk); #1;
    end
    reset = 1'b1;

    // write r3 then r1, with bypass visible during the write cycle
    cyc(); wr(3'd3, 8'd35); readAddrA = 3'd3; readAddrB = 3'd1;
    push("byp_r3", 0, 8'd35); push("nobyp_r3", 4, 8'd0); push("r1_old", 1, 8'd0);
    cyc(); wr(3'd1, 8'd53);
    push("r3_stored", 0, 8'd35); push("byp_r1", 1, 8'd53); push("nobyp_r3_stored", 4, 8'd35);
    cyc(); write = 1'b0;
    push("r3_hold", 0, 8'd35); push("r1_stored", 1, 8'd53);

    // fill and sweep: entry k clears at edge N+1+k
    for (int k = 0; k < 8; k++) begin
      cyc(); wr(3'(k), 8'(8'h10 + k));
    end
    cyc(); write = 1'b0; clr = 1'b1;
    push("pre_clr_busy", 2, 8'h0);
    for (int m = 0; m <= 8; m++) begin
      cyc(); clr = 1'b0;
      if (m == 0) begin
        readAddrA = 3'd0; readAddrB = 3'd1;
        push("sw_r0_old", 0, 8'h10); push("sw_r1_old", 1, 8'h11);
      end else if (m < 8) begin
        readAddrA = 3'(m - 1); readAddrB = 3'(m);
        push("sw_cleared", 0, 8'h00); push("sw_unswept", 1, 8'(8'h10 + m));
      end else begin
        readAddrA = 3'd7; readAddrB = 3'd0;
        push("sw_done_r7", 0, 8'h00); push("sw_done_r0", 1, 8'h00);
      end
      push("sw_busy", 2, (m < 8) ? 8'h1 : 8'h0);
    end

    // write during sweep is dropped, second clr does not extend the sweep
    cyc(); wr(3'd5, 8'h55);
    cyc(); write = 1'b0; clr = 1'b1;
    for (int m = 0; m <= 8; m++) begin
      cyc(); clr = 1'b0; write = 1'b0; readAddrA = 3'd5;
      if (m == 2) begin
        wr(3'd5, 8'd98); clr = 1'b1;
        push("busy_no_byp", 0, 8'h55); push("drop_not_yet", 3, 8'h0);
      end
      if (m == 3) push("drop_pulse", 3, 8'h1);
      if (m == 4) begin push("drop_end", 3, 8'h0); push("r5_not_written", 0, 8'h55); end
      if (m == 8) push("r5_after_sweep", 0, 8'h00);
      push("busy2", 2, (m < 8) ? 8'h1 : 8'h0);
    end

    // reset in the middle of a sweep
    cyc(); wr(3'd2, 8'h22);
    cyc(); wr(3'd6, 8'h66);
    cyc(); write = 1'b0; clr = 1'b1;
    for (int m = 0; m < 3; m++) begin
      cyc(); clr = 1'b0;
    end
    readAddrA = 3'd6;
    push("r6_before_rst", 0, 8'h66);
    cyc(); reset = 1'b0; readAddrA = 3'd6; readAddrB = 3'd2;
    push("midrst_r6", 0, 8'h00); push("midrst_r2", 1, 8'h00);
    push("midrst_busy", 2, 8'h0); push("midrst_drop", 3, 8'h0);
    cyc(); reset = 1'b1; wr(3'd7, 8'd24); readAddrA = 3'd7;
    push("post_rst_byp", 0, 8'd24); push("post_rst_nobyp", 4, 8'd0); push("post_rst_busy", 2, 8'h0);
    cyc(); write = 1'b0;
    push("post_rst_r7", 0, 8'd24); push("post_rst_nb_r7", 4, 8'd24);

    // hardwired zero register
    cyc(); wr(3'd0, 8'd15); readAddrA = 3'd0;
    push("z_wr_cycle", 5, 8'd0); push("nz_byp_r0", 0, 8'd15);
    cyc(); write = 1'b0;
    push("z_after", 5, 8'd0); push("z_no_drop", 6, 8'h0); push("nz_r0", 0, 8'd15);

    cyc(); @(negedge clk); #1;
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
